// File: rtl/bound_flasher_ctrl_if.sv
// Lamp-bank bus for the Bound Flasher: flick request in, lamp bar and status out.
// master = whoever issues flick, slave = the controller.
interface bound_flasher_ctrl_if #(
  parameter int N_LAMPS = 16
);
  logic               flick;
  logic [N_LAMPS-1:0] lamp;
  logic [2:0]         state;
  logic               busy;
  logic               done;

  modport master (output flick, input lamp, state, busy, done);
  modport slave  (input flick, output lamp, state, busy, done);
endinterface

// File: rtl/bound_flasher_ctrl.sv
// Bound Flasher controller: a level register stepped +/-1 at a prescaled rate, a
// seven-state sweep sequence with flick kickbacks, and a thermometer lamp output.
module bound_flasher_ctrl #(
  parameter int N_LAMPS  = 16,
  parameter int B1       = 6,
  parameter int B2       = 11,
  parameter int FLOOR    = 5,
  parameter int STEP_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  bound_flasher_ctrl_if.slave  bus
);
  localparam int LW = $clog2(N_LAMPS + 1);
  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] DIV_TOP = DW'(STEP_DIV - 1);

  if (!(FLOOR > 0 && FLOOR < B1 && B1 < B2 && B2 < N_LAMPS && STEP_DIV >= 1)) begin : g_bad_params
    $error("bound_flasher_ctrl: need 0 < FLOOR < B1 < B2 < N_LAMPS and STEP_DIV >= 1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP1  = 3'd1,
    DN1  = 3'd2,
    UP2  = 3'd3,
    DN2  = 3'd4,
    UP3  = 3'd5,
    DN3  = 3'd6
  } state_t;

  state_t             r_state, w_state_next;
  logic [LW-1:0]      r_level, w_level_next, w_ln;
  logic [DW-1:0]      r_div, w_div_next;
  logic [N_LAMPS-1:0] r_lamp, w_lamp_next;
  logic               r_busy, r_done, w_done_next;
  logic               w_step, w_up, w_at_bound;

  assign w_step     = (r_state != IDLE) && (r_div == DIV_TOP);
  assign w_up       = (r_state == UP1) || (r_state == UP2) || (r_state == UP3);
  assign w_ln       = w_up ? (r_level + LW'(1)) : (r_level - LW'(1));
  assign w_at_bound = (w_ln == LW'(B1)) || (w_ln == LW'(B2));

  // Transitions are decided on the post-step level so each peak shows for one step.
  always_comb begin
    w_state_next = r_state;
    w_level_next = r_level;
    w_div_next   = r_div;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        w_div_next = '0;
        if (bus.flick) begin
          w_state_next = UP1;
          w_level_next = '0;
        end
      end
      UP1, DN1, UP2, DN2, UP3, DN3: begin
        w_div_next = (r_div == DIV_TOP) ? '0 : r_div + DW'(1);
        if (w_step) begin
          w_level_next = w_ln;
          case (r_state)
            UP1: if (w_ln == LW'(B1)) w_state_next = DN1;
            DN1: if (w_ln == '0) w_state_next = UP2;
            UP2: begin
              if (bus.flick && w_at_bound)  w_state_next = DN1;
              else if (w_ln == LW'(B2))     w_state_next = DN2;
            end
            DN2: if (w_ln == LW'(FLOOR)) w_state_next = UP3;
            UP3: begin
              if (bus.flick && w_at_bound)  w_state_next = DN2;
              else if (w_ln == LW'(N_LAMPS)) w_state_next = DN3;
            end
            DN3: begin
              if (w_ln == '0) begin
                w_state_next = IDLE;
                w_done_next  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      default: begin
        // Unreachable code 7: recover to a clean idle.
        w_state_next = IDLE;
        w_level_next = '0;
        w_div_next   = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < N_LAMPS; gi++) begin : g_therm
    assign w_lamp_next[gi] = (w_level_next > LW'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_level <= '0;
      r_div   <= '0;
      r_lamp  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_level <= w_level_next;
      r_div   <= w_div_next;
      r_lamp  <= w_lamp_next;
      r_busy  <= (w_state_next != IDLE);
      r_done  <= w_done_next;
    end
  end

  assign bus.lamp  = r_lamp;
  assign bus.state = r_state;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Directed bench for bound_flasher_ctrl: default build, a STEP_DIV=4 build and an
// 8-lamp build, with expected lamp bars walked from the bound table.
module tb_bound_flasher_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bound_flasher_ctrl_if #(.N_LAMPS(16)) bus_a ();
  bound_flasher_ctrl_if #(.N_LAMPS(8))  bus_b ();
  bound_flasher_ctrl_if #(.N_LAMPS(16)) bus_c ();

  bound_flasher_ctrl #(.N_LAMPS(16), .B1(6), .B2(11), .FLOOR(5), .STEP_DIV(1)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  bound_flasher_ctrl #(.N_LAMPS(8), .B1(3), .B2(6), .FLOOR(2), .STEP_DIV(1)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));
  bound_flasher_ctrl #(.N_LAMPS(16), .B1(6), .B2(11), .FLOOR(5), .STEP_DIV(4)) u_dut_c (
    .clk(clk), .rst(rst), .bus(bus_c));

  int n_cmp = 0;
  int n_err = 0;
  int sel   = 0;

  logic [15:0] o_lamp;
  logic [2:0]  o_state;
  logic        o_busy, o_done;

  always_comb begin
    o_lamp  = '0;
    o_state = '0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (sel)
      0: begin
        o_lamp = bus_a.lamp; o_state = bus_a.state; o_busy = bus_a.busy; o_done = bus_a.done;
      end
      1: begin
        o_lamp = {8'h00, bus_b.lamp}; o_state = bus_b.state; o_busy = bus_b.busy; o_done = bus_b.done;
      end
      default: begin
        o_lamp = bus_c.lamp; o_state = bus_c.state; o_busy = bus_c.busy; o_done = bus_c.done;
      end
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] therm(input int l);
    return (32'd1 << l) - 32'd1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flick(input logic v);
    bus_a.flick = (sel == 0) ? v : 1'b0;
    bus_b.flick = (sel == 1) ? v : 1'b0;
    bus_c.flick = (sel == 2) ? v : 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_lamp"},  32'(o_lamp),  32'd0);
    check_val({tag, "_state"}, 32'(o_state), 32'd0);
    check_val({tag, "_busy"},  32'(o_busy),  32'd0);
    check_val({tag, "_done"},  32'(o_done),  32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    set_flick(1'b0);
    tick();
    check_idle(tag);
    rst = 1'b0;
    $display("reset %s: outputs idle", tag);
  endtask

  task automatic pulse_start();
    set_flick(1'b1);
    tick();
    set_flick(1'b0);
  endtask

  // Full sweep walked from the bound table: each step moves one lamp toward the
  // segment target; the state flips to the next segment on the step reaching it.
  task automatic run_full(input string tag, input int n, input int b1, input int b2,
                          input int fl, input int dv);
    int tgt[6];
    int lvl;
    int steps;
    int dones;
    tgt   = '{b1, 0, b2, fl, n, 0};
    lvl   = 0;
    steps = 0;
    dones = 0;
    pulse_start();
    check_val({tag, "_start_state"}, 32'(o_state), 32'd1);
    check_val({tag, "_start_busy"},  32'(o_busy),  32'd1);
    check_val({tag, "_start_lamp"},  32'(o_lamp),  32'd0);
    for (int seg = 0; seg < 6; seg++) begin
      while (lvl != tgt[seg]) begin
        for (int w = 0; w < dv - 1; w++) begin
          tick();
          check_val({tag, "_hold_lamp"}, 32'(o_lamp), therm(lvl));
          if (o_done) dones++;
        end
        lvl = (lvl < tgt[seg]) ? lvl + 1 : lvl - 1;
        tick();
        steps++;
        if (o_done) dones++;
        check_val({tag, "_lamp"}, 32'(o_lamp), therm(lvl));
        if (lvl == tgt[seg])
          check_val({tag, "_state"}, 32'(o_state), (seg == 5) ? 32'd0 : 32'(seg + 2));
        else
          check_val({tag, "_state"}, 32'(o_state), 32'(seg + 1));
        check_val({tag, "_done"}, 32'(o_done), (seg == 5 && lvl == 0) ? 32'd1 : 32'd0);
      end
    end
    tick();
    if (o_done) dones++;
    check_val({tag, "_done_count"}, 32'(dones), 32'd1);
    check_idle({tag, "_after"});
    $display("sweep %s: %0d steps, step spacing %0d", tag, steps, dv);
  endtask

  initial begin
    bus_a.flick = 1'b0;
    bus_b.flick = 1'b0;
    bus_c.flick = 1'b0;

    // Reset held with flick high: nothing may start.
    rst = 1'b1;
    sel = 0;
    set_flick(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("rst_hold");
    end
    $display("reset hold with flick high: 5 cycles");
    set_flick(1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_idle("idle");
    end
    $display("idle with flick low: 20 cycles");

    run_full("full16", 16, 6, 11, 5, 1);

    // UP2 kickback at B1: lamp falls back to zero and UP2 restarts.
    pulse_start();
    repeat (12) tick();
    check_val("kb2_in_up2", 32'(o_state), 32'd3);
    repeat (5) tick();
    set_flick(1'b1);
    tick();
    set_flick(1'b0);
    check_val("kb2_state", 32'(o_state), 32'd2);
    check_val("kb2_peak",  32'(o_lamp),  32'h003F);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_val("kb2_down_lamp",  32'(o_lamp),  therm(6 - k));
      check_val("kb2_down_state", 32'(o_state), (k == 6) ? 32'd3 : 32'd2);
    end
    tick();
    check_val("kb2_restart_lamp",  32'(o_lamp),  32'h0001);
    check_val("kb2_restart_state", 32'(o_state), 32'd3);
    $display("kickback in UP2 at B1: back to 0, UP2 restarted");
    do_reset("kb2_rst");

    // UP3 kickback at B2: fall to FLOOR (flick held through DN2 is ignored), then resume.
    pulse_start();
    repeat (29) tick();
    check_val("kb3_in_up3", 32'(o_state), 32'd5);
    check_val("kb3_floor",  32'(o_lamp),  32'h001F);
    repeat (5) tick();
    set_flick(1'b1);
    tick();
    check_val("kb3_state", 32'(o_state), 32'd4);
    check_val("kb3_peak",  32'(o_lamp),  32'h07FF);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_val("kb3_down_lamp",  32'(o_lamp),  therm(11 - k));
      check_val("kb3_down_state", 32'(o_state), (k == 6) ? 32'd5 : 32'd4);
    end
    set_flick(1'b0);
    repeat (11) tick();
    check_val("kb3_top_lamp",  32'(o_lamp),  32'hFFFF);
    check_val("kb3_top_state", 32'(o_state), 32'd6);
    $display("kickback in UP3 at B2: down to FLOOR, resumed to full bar");
    do_reset("kb3_rst");

    // flick held high: UP1 ignores it, then UP2 and DN1 loop on 0..B1.
    set_flick(1'b1);
    tick();
    repeat (18) tick();
    check_val("loop_state", 32'(o_state), 32'd2);
    check_val("loop_lamp",  32'(o_lamp),  32'h003F);
    repeat (6) tick();
    check_val("loop_back_state", 32'(o_state), 32'd3);
    check_val("loop_back_lamp",  32'(o_lamp),  32'h0000);
    $display("flick held high: UP2/DN1 loop observed");
    do_reset("loop_rst");

    // Reset in the middle of DN2: everything clears, done never fires.
    pulse_start();
    repeat (25) tick();
    check_val("mid_state", 32'(o_state), 32'd4);
    check_val("mid_lamp",  32'(o_lamp),  32'h01FF);
    do_reset("mid_rst");
    begin
      int dones;
      dones = 0;
      for (int i = 0; i < 60; i++) begin
        tick();
        if (o_done || o_busy) dones++;
      end
      check_val("mid_no_done", 32'(dones), 32'd0);
    end
    $display("reset during DN2: no done, stays idle");

    sel = 2;
    run_full("div4", 16, 6, 11, 5, 4);

    sel = 1;
    run_full("full8", 8, 3, 6, 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
